// File: rtl/data_port_a_lsu.sv
// data_port_a_lsu
//   Load/store unit owning port A of the dual-port data RAM. In-order word loads and stores
//   arrive over a valid/ready handshake. The unit drives the RAM port A address, data and
//   write enable combinationally from the request, tracks each accepted request through a
//   READ_LATENCY-deep tag pipeline, and queues exactly one response per request in a small
//   FIFO. Acceptance is credit based, so neither the FIFO nor a returning RAM word is dropped.
//
// Ports
//   clk_50M      in   clock, rising edge
//   reset        in   synchronous, active high
//   req_valid    in   request present
//   req_ready    out  request can be accepted this cycle
//   req_write    in   1 = store, 0 = load
//   req_addr     in   word address
//   req_wdata    in   store data
//   resp_valid   out  response present
//   resp_ready   in   consumer takes the response
//   resp_rdata   out  load data (0 for stores and errors)
//   resp_err     out  request address was out of range
//   resp_write   out  echo of req_write
//   mem_address  out  RAM address_a
//   mem_write    out  RAM data_a
//   mem_wren     out  RAM wren_a
//   mem_read     in   RAM q_a
module data_port_a_lsu #(
  parameter int unsigned ADDR_WIDTH   = 18,
  parameter int unsigned DATA_WIDTH   = 18,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk_50M,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  resp_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_read
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

  logic                    w_in_range;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic [DATA_WIDTH-1:0]   w_push_rdata;
  logic [CNT_W-1:0]        w_inflight;
  logic [CNT_W-1:0]        w_used;

  logic [READ_LATENCY-1:0] r_pipe_valid;
  logic [READ_LATENCY-1:0] r_pipe_write;
  logic [READ_LATENCY-1:0] r_pipe_err;

  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W:0]          r_count;
  logic [DATA_WIDTH-1:0]   r_fifo_rdata [FIFO_DEPTH];
  logic                    r_fifo_write [FIFO_DEPTH];
  logic                    r_fifo_err   [FIFO_DEPTH];

  // Compare one bit wider so MEM_WORDS == 2**ADDR_WIDTH still works.
  assign w_in_range = ({1'b0, req_addr} < (ADDR_WIDTH + 1)'(MEM_WORDS));

  // Credits come from registered state only: a pop in this cycle frees a slot next cycle.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + CNT_W'(r_pipe_valid[i]);
    end
  end

  assign w_used    = w_inflight + CNT_W'(r_count);
  assign req_ready = !reset && (w_used < CNT_W'(FIFO_DEPTH));
  assign w_accept  = req_valid && req_ready;

  assign mem_address = req_addr;
  assign mem_write   = req_wdata;
  assign mem_wren    = w_accept && req_write && w_in_range;

  // The last pipeline stage lines up with the RAM word for that request.
  assign w_push       = r_pipe_valid[READ_LATENCY-1];
  assign w_push_rdata = (!r_pipe_write[READ_LATENCY-1] && !r_pipe_err[READ_LATENCY-1]) ?
                        mem_read : '0;

  assign resp_valid = (r_count != '0);
  assign w_pop      = resp_valid && resp_ready;

  // Gate the head so stale storage never shows after reset or when empty.
  assign resp_rdata = resp_valid ? r_fifo_rdata[r_rd_ptr] : '0;
  assign resp_write = resp_valid && r_fifo_write[r_rd_ptr];
  assign resp_err   = resp_valid && r_fifo_err[r_rd_ptr];

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_pipe_valid <= '0;
    end else begin
      r_pipe_valid[0] <= w_accept;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
      end
    end
  end

  // Tag payload is only meaningful alongside its valid bit, so it needs no reset.
  always_ff @(posedge clk_50M) begin
    r_pipe_write[0] <= req_write;
    r_pipe_err[0]   <= !w_in_range;
    for (int i = 1; i < READ_LATENCY; i++) begin
      r_pipe_write[i] <= r_pipe_write[i-1];
      r_pipe_err[i]   <= r_pipe_err[i-1];
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (w_push) begin
      r_fifo_rdata[r_wr_ptr] <= w_push_rdata;
      r_fifo_write[r_wr_ptr] <= r_pipe_write[READ_LATENCY-1];
      r_fifo_err[r_wr_ptr]   <= r_pipe_err[READ_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_data_port_a_lsu.sv
module tb_data_port_a_lsu;

  localparam int AW    = 18;
  localparam int DW    = 18;
  localparam int WORDS = 1024;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          resp_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write;
  logic          mem_wren;
  logic [DW-1:0] mem_read;

  data_port_a_lsu #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MEM_WORDS   (WORDS),
    .READ_LATENCY(2),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_50M    (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .resp_write (resp_write),
    .mem_address(mem_address),
    .mem_write  (mem_write),
    .mem_wren   (mem_wren),
    .mem_read   (mem_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port A of the RAM: registered address, registered output -> two-edge read latency.
  logic [DW-1:0] ram [WORDS];
  logic [9:0]    ram_addr_q;
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address[9:0]] <= mem_write;
    ram_addr_q <= mem_address[9:0];
    ram_q      <= ram[ram_addr_q];
  end
  assign mem_read = ram_q;

  typedef struct packed {
    logic          wr;
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  typedef struct {
    int            cyc;
    logic          acc;
    logic          pop;
    logic          ready;
    logic          exp_ready;
    logic          wren;
    logic          exp_wren;
    logic          have_exp;
    logic [AW-1:0] maddr;
    rsp_t          rsp;
    rsp_t          exp_rsp;
  } obs_t;

  // Reference model: shadow memory, in-order queue of expected responses, and the count of
  // requests outstanding (accepted but not yet taken) which bounds acceptance.
  logic [DW-1:0] ref_mem [WORDS];
  rsp_t          exp_q [$];
  int            n_acc, n_pop, cyc;
  int            nvec, nerr;

  // Observe one cycle (inputs already driven), advance one clock, update the model.
  task automatic tick(output obs_t o);
    rsp_t e;
    #1;
    o.cyc       = cyc;
    o.ready     = req_ready;
    o.exp_ready = !reset && ((n_acc - n_pop) < DEPTH);
    o.acc       = req_valid && req_ready;
    o.exp_wren  = o.acc && req_write && (req_addr < AW'(WORDS));
    o.wren      = mem_wren;
    o.maddr     = mem_address;
    o.pop       = !reset && resp_valid && resp_ready;
    o.rsp       = {resp_write, resp_err, resp_rdata};
    o.have_exp  = 1'b0;
    o.exp_rsp   = '0;
    if (o.pop && exp_q.size() > 0) begin
      o.exp_rsp  = exp_q.pop_front();
      o.have_exp = 1'b1;
    end
    if (o.acc && !reset) begin
      e.wr    = req_write;
      e.err   = (req_addr >= AW'(WORDS));
      e.rdata = (!e.wr && !e.err) ? ref_mem[req_addr[9:0]] : '0;
      exp_q.push_back(e);
      if (e.wr && !e.err) ref_mem[req_addr[9:0]] = req_wdata;
    end
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      n_acc = 0;
      n_pop = 0;
    end else begin
      if (o.pop) n_pop++;
      if (o.acc) n_acc++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 3; req_wdata = '1;
    resp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      nvec += 2;
      if ({resp_valid, resp_err, resp_write, mem_wren, req_ready} !== 5'b0) begin
        nerr++;
        $display("FAIL reset_ctl got v/e/w/wren/rdy=%b%b%b%b%b exp=00000",
                 resp_valid, resp_err, resp_write, mem_wren, req_ready);
      end
      if (resp_rdata !== '0) begin
        nerr++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata);
      end
      tick(o);
    end
    reset = 1'b0; req_valid = 1'b0;
    #1;
    nvec++;
    if (req_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_release_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_store_load();
    obs_t o;
    string nm = "store_load";
    int   step = 0, npop = 0, wren_cnt = 0, load_cyc = -100;
    int   pop_cyc [2];
    rsp_t got [2];
    rsp_t want0, want1;
    want0 = {1'b1, 1'b0, 18'h0};
    want1 = {1'b0, 1'b0, 18'h2ABCD};
    resp_ready = 1'b1;
    for (int k = 0; k < 30 && npop < 2; k++) begin
      req_valid = (step < 2); req_write = (step == 0); req_addr = 5; req_wdata = 18'h2ABCD;
      tick(o);
      nvec += 2;
      if (o.ready !== o.exp_ready) begin
        nerr++; $display("FAIL %s req_ready cyc=%0d got=%b exp=%b", nm, o.cyc, o.ready, o.exp_ready);
      end
      if (o.wren !== o.exp_wren) begin
        nerr++; $display("FAIL %s mem_wren cyc=%0d got=%b exp=%b", nm, o.cyc, o.wren, o.exp_wren);
      end
      if (o.pop) begin
        nvec++;
        if (!o.have_exp || o.rsp !== o.exp_rsp) begin
          nerr++; $display("FAIL %s resp cyc=%0d got=%h exp=%h", nm, o.cyc, o.rsp, o.exp_rsp);
        end
        if (npop < 2) begin got[npop] = o.rsp; pop_cyc[npop] = o.cyc; end
        npop++;
      end
      if (o.wren) begin
        wren_cnt++;
        nvec++;
        if (o.maddr !== AW'(5)) begin
          nerr++; $display("FAIL %s wren_addr got=%h exp=5", nm, o.maddr);
        end
      end
      if (o.acc) begin
        if (step == 1) load_cyc = o.cyc;
        step++;
      end
    end
    req_valid = 1'b0;
    nvec += 5;
    if (npop !== 2) begin nerr++; $display("FAIL %s resp_count got=%0d exp=2", nm, npop); end
    if (wren_cnt !== 1) begin nerr++; $display("FAIL %s wren_cycles got=%0d exp=1", nm, wren_cnt); end
    if (got[0] !== want0) begin nerr++; $display("FAIL %s first got=%h exp=%h", nm, got[0], want0); end
    if (got[1] !== want1) begin nerr++; $display("FAIL %s second got=%h exp=%h", nm, got[1], want1); end
    if (pop_cyc[1] !== load_cyc + 3) begin
      nerr++; $display("FAIL %s latency got=%0d exp=%0d", nm, pop_cyc[1], load_cyc + 3);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    string nm = "back_to_back";
    int idx = 0, npop = 0, nld = 0;
    int ld_cyc [8];
    logic [DW-1:0] ld_data [8];
    resp_ready = 1'b1;
    for (int k = 0; k < 60 && npop < 16; k++) begin
      req_valid = (idx < 16);
      req_write = (idx < 8);
      req_addr  = AW'(idx % 8);
      req_wdata = DW'((idx % 8) * 3);
      tick(o);
      nvec += 2;
      if (o.ready !== o.exp_ready) begin
        nerr++; $display("FAIL %s req_ready cyc=%0d got=%b exp=%b", nm, o.cyc, o.ready, o.exp_ready);
      end
      if (o.wren !== o.exp_wren) begin
        nerr++; $display("FAIL %s mem_wren cyc=%0d got=%b exp=%b", nm, o.cyc, o.wren, o.exp_wren);
      end
      if (o.pop) begin
        nvec++;
        if (!o.have_exp || o.rsp !== o.exp_rsp) begin
          nerr++; $display("FAIL %s resp cyc=%0d got=%h exp=%h", nm, o.cyc, o.rsp, o.exp_rsp);
        end
        if (!o.rsp.wr && nld < 8) begin
          ld_cyc[nld] = o.cyc; ld_data[nld] = o.rsp.rdata; nld++;
        end
        npop++;
      end
      if (o.acc) idx++;
    end
    req_valid = 1'b0;
    nvec++;
    if (nld !== 8) begin nerr++; $display("FAIL %s loads got=%0d exp=8", nm, nld); end
    for (int i = 0; i < nld; i++) begin
      nvec++;
      if (ld_data[i] !== DW'(i * 3)) begin
        nerr++; $display("FAIL %s rdata[%0d] got=%0d exp=%0d", nm, i, ld_data[i], i * 3);
      end
      if (i > 0) begin
        nvec++;
        if (ld_cyc[i] !== ld_cyc[i-1] + 1) begin
          nerr++; $display("FAIL %s gap[%0d] got=%0d exp=1", nm, i, ld_cyc[i] - ld_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    string nm = "backpressure";
    int idx = 0, npop = 0, first_pop = -1, fifth_acc = -1;
    logic last_ready = 1'b1;
    logic [DW-1:0] seq [6];
    resp_ready = 1'b0;
    for (int k = 0; k < 60 && npop < 6; k++) begin
      if (k == 8) begin
        nvec += 2;
        if (idx !== 4) begin nerr++; $display("FAIL %s accepted got=%0d exp=4", nm, idx); end
        if (last_ready !== 1'b0) begin
          nerr++; $display("FAIL %s ready_when_full got=%b exp=0", nm, last_ready);
        end
        resp_ready = 1'b1;
      end
      req_valid = (idx < 6); req_write = 1'b0; req_addr = AW'(idx);
      tick(o);
      last_ready = o.ready;
      nvec += 2;
      if (o.ready !== o.exp_ready) begin
        nerr++; $display("FAIL %s req_ready cyc=%0d got=%b exp=%b", nm, o.cyc, o.ready, o.exp_ready);
      end
      if (o.wren !== o.exp_wren) begin
        nerr++; $display("FAIL %s mem_wren cyc=%0d got=%b exp=%b", nm, o.cyc, o.wren, o.exp_wren);
      end
      if (o.pop) begin
        nvec++;
        if (!o.have_exp || o.rsp !== o.exp_rsp) begin
          nerr++; $display("FAIL %s resp cyc=%0d got=%h exp=%h", nm, o.cyc, o.rsp, o.exp_rsp);
        end
        if (first_pop < 0) first_pop = o.cyc;
        if (npop < 6) seq[npop] = o.rsp.rdata;
        npop++;
      end
      if (o.acc) begin
        if (idx == 4) fifth_acc = o.cyc;
        idx++;
      end
    end
    req_valid = 1'b0;
    nvec += 2;
    if (npop !== 6) begin nerr++; $display("FAIL %s drained got=%0d exp=6", nm, npop); end
    if (fifth_acc <= first_pop) begin
      nerr++; $display("FAIL %s fifth_accept cyc=%0d must follow first pop cyc=%0d",
                       nm, fifth_acc, first_pop);
    end
    for (int i = 0; i < npop && i < 6; i++) begin
      nvec++;
      if (seq[i] !== DW'(i * 3)) begin
        nerr++; $display("FAIL %s order[%0d] got=%0d exp=%0d", nm, i, seq[i], i * 3);
      end
    end
  endtask

  task automatic test_out_of_range();
    obs_t o;
    string nm = "out_of_range";
    int idx = 0, npop = 0, any_wren = 0;
    logic [AW-1:0] addrs [3];
    rsp_t got [3];
    rsp_t want [3];
    addrs[0] = 18'h00400; addrs[1] = 18'h3FFFF; addrs[2] = 18'h00000;
    want[0] = {1'b1, 1'b1, 18'h0};
    want[1] = {1'b0, 1'b1, 18'h0};
    want[2] = {1'b0, 1'b0, 18'h0};   // address 0 still holds 0*3
    resp_ready = 1'b1;
    for (int k = 0; k < 30 && npop < 3; k++) begin
      req_valid = (idx < 3); req_write = (idx == 0);
      req_addr  = addrs[idx < 3 ? idx : 0]; req_wdata = 18'h15555;
      tick(o);
      nvec += 2;
      if (o.ready !== o.exp_ready) begin
        nerr++; $display("FAIL %s req_ready cyc=%0d got=%b exp=%b", nm, o.cyc, o.ready, o.exp_ready);
      end
      if (o.wren !== o.exp_wren) begin
        nerr++; $display("FAIL %s mem_wren cyc=%0d got=%b exp=%b", nm, o.cyc, o.wren, o.exp_wren);
      end
      if (o.pop) begin
        nvec++;
        if (!o.have_exp || o.rsp !== o.exp_rsp) begin
          nerr++; $display("FAIL %s resp cyc=%0d got=%h exp=%h", nm, o.cyc, o.rsp, o.exp_rsp);
        end
        if (npop < 3) got[npop] = o.rsp;
        npop++;
      end
      if (o.wren) any_wren++;
      if (o.acc) idx++;
    end
    req_valid = 1'b0;
    nvec += 2;
    if (npop !== 3) begin nerr++; $display("FAIL %s resp_count got=%0d exp=3", nm, npop); end
    if (any_wren !== 0) begin nerr++; $display("FAIL %s wren_cycles got=%0d exp=0", nm, any_wren); end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (got[i] !== want[i]) begin
        nerr++; $display("FAIL %s resp[%0d] got=%h exp=%h", nm, i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    obs_t o;
    string nm = "reset_midflight";
    int idx = 0, stray = 0, acc_cyc = -100, pop_cyc = -1;
    logic [DW-1:0] data = '0;
    resp_ready = 1'b0;
    // Three back-to-back loads: one reaches the FIFO while two are still in the pipeline.
    for (int k = 0; k < 10 && idx < 3; k++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(idx + 1);
      tick(o);
      if (o.acc) idx++;
    end
    req_valid = 1'b0;
    reset = 1'b1;
    tick(o);
    nvec++;
    if (o.ready !== 1'b0) begin nerr++; $display("FAIL %s ready_in_reset got=%b exp=0", nm, o.ready); end
    reset = 1'b0; resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(o);
      if (k == 0) begin
        nvec++;
        if (o.ready !== 1'b1) begin nerr++; $display("FAIL %s ready_after got=%b exp=1", nm, o.ready); end
      end
      if (o.pop) stray++;
    end
    nvec++;
    if (stray !== 0) begin nerr++; $display("FAIL %s stray_responses got=%0d exp=0", nm, stray); end
    idx = 0;
    for (int k = 0; k < 20 && pop_cyc < 0; k++) begin
      req_valid = (idx == 0); req_write = 1'b0; req_addr = 7;
      tick(o);
      if (o.acc) begin acc_cyc = o.cyc; idx++; end
      if (o.pop) begin pop_cyc = o.cyc; data = o.rsp.rdata; end
    end
    req_valid = 1'b0;
    nvec += 2;
    if (data !== DW'(21)) begin nerr++; $display("FAIL %s new_load got=%0d exp=21", nm, data); end
    if (pop_cyc !== acc_cyc + 3) begin
      nerr++; $display("FAIL %s new_latency got=%0d exp=%0d", nm, pop_cyc, acc_cyc + 3);
    end
  endtask

  task automatic test_random();
    obs_t o;
    string nm = "random";
    logic accepted = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (!req_valid || accepted) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_write = $urandom_range(0, 1) == 1;
        req_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(WORDS, (1 << AW) - 1))
                                                : AW'($urandom_range(0, 31));
        req_wdata = DW'($urandom);
      end
      resp_ready = ($urandom_range(0, 2) != 0);
      if (k >= 380) begin req_valid = 1'b0; resp_ready = 1'b1; end
      tick(o);
      accepted = o.acc;
      nvec += 2;
      if (o.ready !== o.exp_ready) begin
        nerr++; $display("FAIL %s req_ready cyc=%0d got=%b exp=%b", nm, o.cyc, o.ready, o.exp_ready);
      end
      if (o.wren !== o.exp_wren) begin
        nerr++; $display("FAIL %s mem_wren cyc=%0d got=%b exp=%b", nm, o.cyc, o.wren, o.exp_wren);
      end
      if (o.pop) begin
        nvec++;
        if (!o.have_exp || o.rsp !== o.exp_rsp) begin
          nerr++; $display("FAIL %s resp cyc=%0d got=%h exp=%h", nm, o.cyc, o.rsp, o.exp_rsp);
        end
      end
    end
    #1;
    nvec += 2;
    if (exp_q.size() != 0) begin
      nerr++; $display("FAIL %s undelivered got=%0d exp=0", nm, exp_q.size());
    end
    if (resp_valid !== 1'b0) begin
      nerr++; $display("FAIL %s resp_valid_after_drain got=%b exp=0", nm, resp_valid);
    end
  endtask

  initial begin
    nvec = 0; nerr = 0; n_acc = 0; n_pop = 0; cyc = 0;
    for (int i = 0; i < WORDS; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_store_load();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/data_port_a_lsu.md
# data_port_a_lsu

Load/store unit that owns port A of the 18-bit dual-port data RAM `mem1k`. Port B of the same RAM belongs to `uart_controller`. The unit accepts in-order word read/write requests from the asm18 core over a valid/ready handshake. It drives the RAM port A address, data and write-enable, absorbs the RAM's fixed read latency, and returns exactly one response per request, in order, through a small response FIFO with backpressure.

## Interface
Parameters:
- `ADDR_WIDTH`, 18: request and RAM address width.
- `DATA_WIDTH`, 18: word width.
- `MEM_WORDS`, 1024: number of implemented RAM words. Addresses at or above this value are out of range.
- `READ_LATENCY`, 2: number of clock edges from the RAM sampling the address to `mem_read` being sampled. Legal range 1..3.
- `FIFO_DEPTH`, 4: response FIFO depth. Power of two, at least 2.

Ports:
- `clk_50M`, in, 1: the only clock. All state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: unit can accept a request this cycle.
- `req_write`, in, 1: 1 = store, 0 = load.
- `req_addr`, in, ADDR_WIDTH: word address.
- `req_wdata`, in, DATA_WIDTH: store data.
- `resp_valid`, out, 1: response present.
- `resp_ready`, in, 1: consumer takes the response.
- `resp_rdata`, out, DATA_WIDTH: load data. 0 for stores and for errors.
- `resp_err`, out, 1: request address was out of range.
- `resp_write`, out, 1: echo of `req_write` for this response.
- `mem_address`, out, ADDR_WIDTH: to RAM `address_a`.
- `mem_write`, out, DATA_WIDTH: to RAM `data_a`.
- `mem_wren`, out, 1: to RAM `wren_a`.
- `mem_read`, in, DATA_WIDTH: from RAM `q_a`.

## Operation
- Accept: a request is accepted when `req_valid & req_ready` is high at a rising edge.
- RAM drive is combinational from the request inputs:
  - `mem_address = req_addr`
  - `mem_write = req_wdata`
  - `mem_wren = req_valid & req_ready & req_write & in_range`
  - `in_range = req_addr < MEM_WORDS`
- The RAM samples the address on the same edge that accepts the request.
- Out-of-range requests never assert `mem_wren`. Their response carries `resp_err=1` and `resp_rdata=0`.
- Tag pipeline:
  - Every accepted request, load or store, enters a `READ_LATENCY`-stage shift register carrying {valid, write, err}.
  - At stage exit the entry is pushed into the response FIFO.
  - The pushed rdata is `mem_read` if the entry is a load with err=0, otherwise 0.
- All requests take the same latency, so ordering is inherent. No reordering, no bypass.
- Credit rule: `req_ready = !reset && (inflight + fifo_count) < FIFO_DEPTH`.
  - `inflight` is the number of valid pipeline stages, counted from registered state only.
  - A same-cycle FIFO pop does not free a credit until the next cycle.
  - The FIFO therefore never overflows, and `mem_read` is never dropped.
- FIFO:
  - Registered storage with wrap-around read and write pointers.
  - `resp_valid = (fifo_count != 0)`.
  - A pop occurs when `resp_valid & resp_ready`.
  - A simultaneous push and pop leaves the count unchanged. The head data stays stable while `resp_valid` is high and no pop occurs.
- No arbitration against port B. Same-address, same-cycle conflicts follow the RAM's own behaviour and are outside this block.

## Timing
- Reset, checked at the edge:
  - Clears the pipeline valids, FIFO pointers and count.
  - After reset: `req_ready=0` during any cycle with `reset=1`, and 1 in the first cycle after.
  - `resp_valid=0`, `resp_err=0`, `resp_write=0`, `resp_rdata=0`, `mem_wren=0`.
- Reset mid-operation: in-flight and queued responses are discarded and no responses for them appear. Stores already accepted remain written.
- Latency: a request accepted at the edge ending cycle c produces `resp_valid=1` in cycle c+READ_LATENCY+1 (cycle c+3 at the default), provided the FIFO was empty.
- Throughput: one request per cycle while `resp_ready` stays high.
- Sustained rate with `FIFO_DEPTH=4` and `READ_LATENCY=2`: 1/cycle, since credits return one cycle after each pop.
- A read issued in the cycle after a store to the same address returns the new data.

## Test plan
- Reset, then store 0x2ABCD to address 5, then load from 5 with `resp_ready=1`:
  - `mem_wren` is high for exactly one cycle with `mem_address=5`.
  - Two responses arrive in order: first {write=1, err=0, rdata=0}, then {write=0, rdata=0x2ABCD} in cycle c+3.
- Back-to-back loads of addresses 0..7, preloaded with value = addr×3, with `resp_ready=1`:
  - Eight responses on consecutive cycles with rdata 0, 3, ..., 21.
- `resp_ready=0` while 6 loads are offered:
  - Exactly 4 are accepted, after which `req_ready=0`.
  - Raising `resp_ready` drains the 4 in order, then accepts the remaining 2.
  - Nothing is lost or duplicated.
- Store to address 1024 (0x400), then load from 0x3FFFF:
  - `mem_wren` never asserts.
  - Both responses have `resp_err=1` and `resp_rdata=0`.
  - RAM contents are unchanged.
- Assert `reset` for one cycle with 2 loads in flight and 1 response queued:
  - No responses appear afterward, and `req_ready=1` in the following cycle.
  - A new load returns the correct data with the normal latency.
